// File: rtl/ql_ce_pkg.sv
// Shared types and default constants for the QL clock-enable / bus-slot generator.
package ql_ce_pkg;

  typedef enum logic [1:0] {
    SPD_NORMAL = 2'd0,
    SPD_X2     = 2'd1,
    SPD_X4     = 2'd2
  } spd_t;

  localparam int DEF_DIV_BITS  = 3;
  localparam int DEF_SLOT_BITS = 2;
  localparam int DEF_NUM_TICK  = 2;
  localparam int DEF_TICK_W    = 12;

  // 131 kHz RTC/IPC tick from the system clock
  localparam int RTC_TICK_INC  = 1;
  localparam int RTC_TICK_MOD  = 641;

  function automatic logic [1:0] clamp_speed(input logic [1:0] s, input int max_s);
    if (int'(s) > max_s) return 2'(max_s);
    return s;
  endfunction

endpackage

// File: rtl/ql_ce_gen_tick.sv
// One fractional-rate tick channel: Bresenham accumulator, average rate inc/mod per clock.
// Tick is registered, one clock after the accumulator crossing; no backpressure.
module ql_frac_tick
  import ql_ce_pkg::*;
#(
  parameter int TICK_W = DEF_TICK_W
) (
  input  logic              clk_sys,
  input  logic              RESET,
  input  logic [TICK_W-1:0] inc,
  input  logic [TICK_W-1:0] mod,
  output logic              tick
);

  logic [TICK_W-1:0] acc;
  logic [TICK_W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, inc};

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (mod == '0) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (inc >= mod) begin
      acc  <= '0;
      tick <= 1'b1;
    end else if (sum >= {1'b0, mod}) begin
      // also covers mod lowered below acc: the result is still below the old acc, so it drains
      acc  <= TICK_W'(sum - {1'b0, mod});
      tick <= 1'b1;
    end else begin
      acc  <= sum[TICK_W-1:0];
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/ql_ce_gen.sv
// Bus phase strobes, video/SD enables, CPU slot gating and fractional ticks, all registered.
// Optional QL_CE_SUBCYCLE_EN halves mode-0 CPU access to emulate the 68008 8-bit bus.
module ql_ce_gen
  import ql_ce_pkg::*;
#(
  parameter int DIV_BITS  = DEF_DIV_BITS,
  parameter int SLOT_BITS = DEF_SLOT_BITS,
  parameter int NUM_TICK  = DEF_NUM_TICK,
  parameter int TICK_W    = DEF_TICK_W
) (
  input  logic                       clk_sys,
  input  logic                       RESET,
  input  logic [1:0]                 speed,
  input  logic [NUM_TICK*TICK_W-1:0] tick_inc,
  input  logic [NUM_TICK*TICK_W-1:0] tick_mod,
  output logic                       ce_p,
  output logic                       ce_n,
  output logic                       ce_vid,
  output logic                       ce_sd,
  output logic                       cpu_cycle,
  output logic                       ce_bus_p,
  output logic                       ce_bus_n,
  output logic [NUM_TICK-1:0]        tick
);

  localparam int CW = DIV_BITS + SLOT_BITS;
  localparam logic [DIV_BITS-1:0] PH_N = {1'b1, {(DIV_BITS-1){1'b0}}};

  logic [CW-1:0]        cnt;
  logic [DIV_BITS-1:0]  ph;
  logic [SLOT_BITS-1:0] slot;
  logic [SLOT_BITS-1:0] slot_mask;
  logic [1:0]           spd_q;
  logic                 duty;
  logic                 sub;

  assign ph   = cnt[DIV_BITS-1:0];
  assign slot = cnt[CW-1:DIV_BITS];

  // Slot owned by CPU when slot mod 2^(SLOT_BITS-spd_q) == 0
  assign slot_mask = {SLOT_BITS{1'b1}} >> spd_q;

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      cnt    <= '0;
      ce_p   <= 1'b0;
      ce_n   <= 1'b0;
      ce_vid <= 1'b0;
      ce_sd  <= 1'b0;
      duty   <= 1'b0;
      spd_q  <= clamp_speed(speed, SLOT_BITS);
    end else begin
      cnt    <= cnt + CW'(1);
      ce_p   <= (ph == '0);
      ce_n   <= (ph == PH_N);
      ce_vid <= (ph == '0);
      ce_sd  <= (ph[DIV_BITS-2:0] == '0);
      if (ph == '0)
        duty <= ((slot & slot_mask) == '0);
      // mode changes only at the frame boundary so a CPU slot is never split
      if (&cnt)
        spd_q <= clamp_speed(speed, SLOT_BITS);
    end
  end

`ifdef QL_CE_SUBCYCLE_EN
  always_ff @(posedge clk_sys) begin
    if (RESET)
      sub <= 1'b0;
    else if (spd_q != 2'd0)
      sub <= 1'b1;
    else if (cnt == '0)
      sub <= ~sub;
  end
`else
  assign sub = 1'b1;
`endif

  assign cpu_cycle = duty & sub;
  assign ce_bus_p  = cpu_cycle & ce_p;
  assign ce_bus_n  = cpu_cycle & ce_n;

  for (genvar i = 0; i < NUM_TICK; i++) begin : g_tick
    ql_frac_tick #(.TICK_W(TICK_W)) u_tick (
      .clk_sys (clk_sys),
      .RESET   (RESET),
      .inc     (tick_inc[i*TICK_W +: TICK_W]),
      .mod     (tick_mod[i*TICK_W +: TICK_W]),
      .tick    (tick[i])
    );
  end

endmodule

// File: tb/tb_ql_ce_gen.sv
// Self-checking bench for ql_ce_gen: per-clock reference model, vector table, corner sequences.
module tb_ql_ce_gen;
  import ql_ce_pkg::*;

  logic        clk_sys = 1'b0;
  logic        RESET   = 1'b1;
  logic [1:0]  speed   = 2'd0;
  logic [23:0] tick_inc = '0;
  logic [23:0] tick_mod = '0;
  logic        ce_p, ce_n, ce_vid, ce_sd, cpu_cycle, ce_bus_p, ce_bus_n;
  logic [1:0]  tick;

  ql_ce_gen dut (
    .clk_sys   (clk_sys),
    .RESET     (RESET),
    .speed     (speed),
    .tick_inc  (tick_inc),
    .tick_mod  (tick_mod),
    .ce_p      (ce_p),
    .ce_n      (ce_n),
    .ce_vid    (ce_vid),
    .ce_sd     (ce_sd),
    .cpu_cycle (cpu_cycle),
    .ce_bus_p  (ce_bus_p),
    .ce_bus_n  (ce_bus_n),
    .tick      (tick)
  );

  always #5 clk_sys = ~clk_sys;

`ifdef QL_CE_SUBCYCLE_EN
  localparam int CPU0_64 = 8;
`else
  localparam int CPU0_64 = 16;
`endif

  int checks = 0;
  int failures = 0;
  int nprint = 0;

  // reference model state
  int m_k;
  int m_mode;
  int m_acc [2];
  bit m_duty;
  bit m_sub;
  logic [8:0] m_exp;

  function automatic logic [8:0] outs();
    return {ce_p, ce_n, ce_vid, ce_sd, cpu_cycle, ce_bus_p, ce_bus_n, tick[1], tick[0]};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One clock: capture inputs seen by the edge, advance the model, compare all outputs.
  task automatic step();
    bit r;
    int s, c, ph, slot;
    int inc [2];
    int md [2];
    bit ep, en, esd, ecpu;
    bit et [2];
    r = RESET;
    s = int'(speed);
    inc[0] = int'(tick_inc[11:0]);
    inc[1] = int'(tick_inc[23:12]);
    md[0]  = int'(tick_mod[11:0]);
    md[1]  = int'(tick_mod[23:12]);
    @(posedge clk_sys);
    #1;
    if (r) begin
      m_k = 0;
      m_mode = (s > 2) ? 2 : s;
      m_duty = 0;
      m_sub = 0;
      m_acc[0] = 0;
      m_acc[1] = 0;
      m_exp = '0;
    end else begin
      c = m_k % 32;
      ph = c % 8;
      slot = c / 8;
      ep = (ph == 0);
      en = (ph == 4);
      esd = (ph % 4 == 0);
      if (ph == 0) m_duty = ((slot % (4 >> m_mode)) == 0);
`ifdef QL_CE_SUBCYCLE_EN
      if (m_mode != 0) m_sub = 1;
      else if (c == 0) m_sub = !m_sub;
`else
      m_sub = 1;
`endif
      if (c == 31) m_mode = (s > 2) ? 2 : s;
      m_k++;
      for (int ch = 0; ch < 2; ch++) begin
        if (md[ch] == 0) begin
          m_acc[ch] = 0; et[ch] = 0;
        end else if (inc[ch] >= md[ch]) begin
          m_acc[ch] = 0; et[ch] = 1;
        end else if (m_acc[ch] + inc[ch] >= md[ch]) begin
          m_acc[ch] = m_acc[ch] + inc[ch] - md[ch]; et[ch] = 1;
        end else begin
          m_acc[ch] = m_acc[ch] + inc[ch]; et[ch] = 0;
        end
      end
      ecpu = m_duty && m_sub;
      m_exp = {ep, en, ep, esd, ecpu, ecpu && ep, ecpu && en, et[1], et[0]};
    end
    checks++;
    if (outs() !== m_exp) begin
      failures++;
      if (nprint < 20)
        $display("FAIL model k=%0d actual=%b required=%b", m_k, outs(), m_exp);
      nprint++;
    end
  endtask

  task automatic do_reset(input int s, input int i0, input int m0, input int i1, input int m1);
    RESET = 1'b1;
    speed = 2'(s);
    tick_inc = {12'(i1), 12'(i0)};
    tick_mod = {12'(m1), 12'(m0)};
    step();
    check("reset_outputs", int'(outs()), 0);
    RESET = 1'b0;
  endtask

  // Strobe placement and tick spacing after reset release (speed 0, ch0 1/641, ch1 3/10).
  task automatic startup_checks(input string tag);
    int fp = 0, sp = 0, fn = 0, sn = 0, sd32 = 0, ov = 0, cpu32 = 0, cpu64 = 0;
    int t0a = 0, t0b = 0, t1cnt = 0, consec = 0;
    bit prev1 = 0;
    for (int i = 1; i <= 1300; i++) begin
      step();
      if (ce_p) begin
        if (fp == 0) fp = i; else if (sp == 0) sp = i;
      end
      if (ce_n) begin
        if (fn == 0) fn = i; else if (sn == 0) sn = i;
      end
      if (i <= 32 && ce_sd) sd32++;
      if (i <= 1000 && ce_p && ce_n) ov++;
      if (i <= 32 && cpu_cycle) cpu32++;
      if (i <= 64 && cpu_cycle) cpu64++;
      if (tick[0]) begin
        if (t0a == 0) t0a = i; else if (t0b == 0) t0b = i;
      end
      if (tick[1] && prev1) consec++;
      prev1 = tick[1];
      if (i <= 1000 && tick[1]) t1cnt++;
    end
    check({tag, "_ce_p_first"}, fp, 1);
    check({tag, "_ce_p_second"}, sp, 9);
    check({tag, "_ce_n_first"}, fn, 5);
    check({tag, "_ce_n_second"}, sn, 13);
    check({tag, "_ce_sd_in_32"}, sd32, 8);
    check({tag, "_p_n_overlap"}, ov, 0);
    check({tag, "_cpu_in_32"}, cpu32, 8);
    check({tag, "_cpu_in_64"}, cpu64, CPU0_64);
    check({tag, "_tick0_first"}, t0a, 641);
    check({tag, "_tick0_spacing"}, t0b - t0a, 641);
    check({tag, "_tick1_in_1000"}, t1cnt, 300);
    check({tag, "_tick1_consecutive"}, consec, 0);
  endtask

  typedef struct {
    int spd, i0, m0, i1, m1, ncyc;
    int n_p, n_cpu, n_t0, n_t1;
  } vec_t;

  initial begin
    vec_t vecs [6];
    int np, ncpu, nt0, nt1, cnt;

    vecs[0] = '{0, 3, 10, 5, 5,    64,  8, CPU0_64, 19, 64};
    vecs[1] = '{1, 0, 0,  7, 5,    64,  8, 32,      0,  64};
    vecs[2] = '{2, 1, 2,  0, 5,    64,  8, 64,      32, 0};
    vecs[3] = '{3, 1, 641, 2, 3,   64,  8, 64,      0,  42};
    vecs[4] = '{2, 0, 0,  1, 2,    512, 64, 512,    0,  256};
    vecs[5] = '{0, 5, 5,  1, 641,  64,  8, CPU0_64, 64, 0};

    // reset release and steady-state strobes/ticks
    do_reset(0, RTC_TICK_INC, RTC_TICK_MOD, 3, 10);
    startup_checks("start");

    // vector table: rates over a whole number of frames from reset
    for (int v = 0; v < 6; v++) begin
      do_reset(vecs[v].spd, vecs[v].i0, vecs[v].m0, vecs[v].i1, vecs[v].m1);
      np = 0; ncpu = 0; nt0 = 0; nt1 = 0;
      for (int i = 0; i < vecs[v].ncyc; i++) begin
        step();
        np += int'(ce_p);
        ncpu += int'(cpu_cycle);
        nt0 += int'(tick[0]);
        nt1 += int'(tick[1]);
      end
      check($sformatf("vec%0d_ce_p", v), np, vecs[v].n_p);
      check($sformatf("vec%0d_cpu", v), ncpu, vecs[v].n_cpu);
      check($sformatf("vec%0d_tick0", v), nt0, vecs[v].n_t0);
      check($sformatf("vec%0d_tick1", v), nt1, vecs[v].n_t1);
    end

    // speed 0 -> 2 at cnt=13: takes effect only at the next frame
    do_reset(0, 0, 0, 0, 0);
    cnt = 0;
    for (int i = 0; i < 13; i++) begin step(); cnt += int'(cpu_cycle); end
    check("switch_cpu_before", cnt, 8);
    speed = SPD_X4;
    cnt = 0;
    for (int i = 0; i < 19; i++) begin step(); cnt += int'(cpu_cycle); end
    check("switch_cpu_rest_of_frame", cnt, 0);
    cnt = 0;
    for (int i = 0; i < 32; i++) begin step(); cnt += int'(cpu_cycle); end
    check("switch_cpu_next_frame", cnt, 32);

    // modulus lowered below the accumulator
    do_reset(0, 1, 641, 0, 0);
    for (int i = 0; i < 300; i++) step();
    tick_mod[11:0] = 12'd10;
    step();
    check("mod_drop_tick_next", int'(tick[0]), 1);
    for (int i = 0; i < 100; i++) step();
    cnt = 0;
    for (int i = 0; i < 100; i++) begin step(); cnt += int'(tick[0]); end
    check("mod_drop_steady_rate", cnt, 10);

    // reset mid-frame (cnt=20, acc=200), then identical restart
    do_reset(0, 0, 641, 3, 10);
    for (int i = 0; i < 12; i++) step();
    tick_inc[11:0] = 12'd1;
    for (int i = 0; i < 200; i++) step();
    check("midreset_cnt_phase", m_k % 32, 20);
    RESET = 1'b1;
    speed = 2'd0;
    step();
    check("midreset_outputs", int'(outs()), 0);
    RESET = 1'b0;
    startup_checks("restart");

    // randomized speed and tick settings against the model
    do_reset(0, 1, 3, 2, 7);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 40) == 0) speed = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 60) == 0) begin
        tick_inc = {12'($urandom_range(0, 45)), 12'($urandom_range(0, 45))};
        tick_mod = {12'($urandom_range(0, 40)), 12'($urandom_range(0, 40))};
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
